// File: rtl/score_display_driver.sv
`default_nettype none
// score_display_driver: snapshots a 3-digit BCD score once per scan frame and
// drives a multiplexed 7-segment display with leading-zero blanking and change flash.
module score_display_driver #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 2,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        enable,
  input  logic [11:0] score_value,
  output logic [6:0]  seg,
  output logic [2:0]  an,
  output logic        updated
);

  localparam int TW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = $clog2(2 * BLINK_FRAMES) + 1;

  localparam logic [TW-1:0] TICK_LAST  = TW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_LOAD = BW'(2 * BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [2:0]    AN_OFF     = (ACTIVE_LOW != 0) ? 3'b111 : 3'b000;

  typedef enum logic [1:0] {
    SLOT_ONES  = 2'd0,
    SLOT_TENS  = 2'd1,
    SLOT_HUNDS = 2'd2
  } slot_t;

  slot_t         slot_q, slot_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [11:0]   snap_q, snap_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          updated_q, updated_d;
  logic [6:0]    seg_q, seg_d;
  logic [2:0]    an_q, an_d;

  logic       tick;
  logic       frame_end;
  logic       score_changed;
  logic       hund_blank;
  logic       tens_blank;
  logic       dark;
  logic [3:0] digit;
  logic       digit_blank;
  logic [2:0] an_sel;
  logic [6:0] seg_code;

  // Active-high segment codes {g,f,e,d,c,b,a}; any non-decimal nibble is a dash.
  function automatic logic [6:0] decode7(input logic [3:0] nib);
    case (nib)
      4'h0:    decode7 = 7'h3F;
      4'h1:    decode7 = 7'h06;
      4'h2:    decode7 = 7'h5B;
      4'h3:    decode7 = 7'h4F;
      4'h4:    decode7 = 7'h66;
      4'h5:    decode7 = 7'h6D;
      4'h6:    decode7 = 7'h7D;
      4'h7:    decode7 = 7'h07;
      4'h8:    decode7 = 7'h7F;
      4'h9:    decode7 = 7'h6F;
      default: decode7 = 7'h40;
    endcase
  endfunction

  assign tick          = (tick_cnt_q == TICK_LAST);
  assign frame_end     = tick && (slot_q == SLOT_HUNDS);
  assign score_changed = (score_value != snap_q);
  assign hund_blank    = (snap_q[11:8] == 4'h0);
  assign tens_blank    = hund_blank && (snap_q[7:4] == 4'h0);
  assign dark          = !enable || blink_cnt_q[0];

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    slot_d      = slot_q;
    snap_d      = snap_q;
    blink_cnt_d = blink_cnt_q;
    updated_d   = 1'b0;

    if (tick) begin
      case (slot_q)
        SLOT_ONES: slot_d = SLOT_TENS;
        SLOT_TENS: slot_d = SLOT_HUNDS;
        default:   slot_d = SLOT_ONES;
      endcase
    end

    // The score is only ever taken at the end of the hundreds slot, so a
    // whole frame is always drawn from one consistent snapshot.
    if (frame_end) begin
      snap_d    = score_value;
      updated_d = score_changed;
      if (score_changed && (BLINK_FRAMES != 0)) begin
        blink_cnt_d = BLINK_LOAD;
      end else if (blink_cnt_q != '0) begin
        blink_cnt_d = blink_cnt_q - 1'b1;
      end
    end

    case (slot_q)
      SLOT_TENS: begin
        digit       = snap_q[7:4];
        digit_blank = tens_blank;
        an_sel      = 3'b010;
      end
      SLOT_HUNDS: begin
        digit       = snap_q[11:8];
        digit_blank = hund_blank;
        an_sel      = 3'b100;
      end
      default: begin
        digit       = snap_q[3:0];
        digit_blank = 1'b0;
        an_sel      = 3'b001;
      end
    endcase

    seg_code = digit_blank ? 7'h00 : decode7(digit);
    if (dark) begin
      an_sel   = 3'b000;
      seg_code = 7'h00;
    end

    // XOR with the idle pattern applies the pin polarity in one place.
    an_d  = an_sel ^ AN_OFF;
    seg_d = seg_code ^ SEG_OFF;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      tick_cnt_q  <= '0;
      slot_q      <= SLOT_ONES;
      snap_q      <= '0;
      blink_cnt_q <= '0;
      updated_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      slot_q      <= slot_d;
      snap_q      <= snap_d;
      blink_cnt_q <= blink_cnt_d;
      updated_q   <= updated_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign updated = updated_q;

endmodule
`default_nettype wire

// File: tb/tb_score_display_driver.sv
`default_nettype none
// Bench for score_display_driver: two instances (active-high and active-low
// pins) share stimulus; per-slot expectations flow through a scoreboard queue.
module tb_score_display_driver;

  localparam int RD = 4;
  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic [11:0] score_value;
  logic [6:0]  seg_h, seg_l;
  logic [2:0]  an_h, an_l;
  logic        upd_h, upd_l;

  always #5 clk = ~clk;

  score_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .ACTIVE_LOW(0)) dut_h (
    .clk(clk), .resetn(resetn), .enable(enable), .score_value(score_value),
    .seg(seg_h), .an(an_h), .updated(upd_h)
  );

  score_display_driver #(.REFRESH_DIV(RD), .BLINK_FRAMES(BF), .ACTIVE_LOW(1)) dut_l (
    .clk(clk), .resetn(resetn), .enable(enable), .score_value(score_value),
    .seg(seg_l), .an(an_l), .updated(upd_l)
  );

  typedef struct {
    logic [2:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [11:0] snap_m;
  int          blink_m;
  logic        upd_m;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] seg_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;
      4'h3: return 7'h4F;  4'h4: return 7'h66;  4'h5: return 7'h6D;
      4'h6: return 7'h7D;  4'h7: return 7'h07;  4'h8: return 7'h7F;
      4'h9: return 7'h6F;  default: return 7'h40;
    endcase
  endfunction

  // s: 0 ones, 1 tens, 2 hundreds
  function automatic exp_t model_slot(input int s, input logic en);
    exp_t       e;
    logic [3:0] nib;
    logic       blank;
    nib   = snap_m[4*s +: 4];
    blank = (s == 2 && snap_m[11:8] == 4'h0) || (s == 1 && snap_m[11:4] == 8'h00);
    if (!en || (blink_m % 2 == 1)) begin
      e.an  = 3'b000;
      e.seg = 7'h00;
    end else begin
      e.an  = 3'(1 << s);
      e.seg = blank ? 7'h00 : seg_ref(nib);
    end
    return e;
  endfunction

  // Entry/exit point: just after a frame-boundary edge (or the last reset edge).
  task automatic frame(input logic [11:0] next_score, input logic en);
    exp_t       e;
    logic [2:0] an_inv;
    logic [6:0] seg_inv;
    check("updated_h", 12'(upd_h), 12'(upd_m));
    check("updated_l", 12'(upd_l), 12'(upd_m));
    enable = en;
    for (int s = 0; s < 3; s++) sb.push_back(model_slot(s, en));
    score_value = next_score;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 1) check("updated_single", 12'(upd_h), 12'h000);
      if (i % 4 == 2) begin
        e       = sb.pop_front();
        an_inv  = ~e.an;
        seg_inv = ~e.seg;
        check("an_h", 12'(an_h), 12'(e.an));
        check("seg_h", 12'(seg_h), 12'(e.seg));
        check("an_l", 12'(an_l), 12'(an_inv));
        check("seg_l", 12'(seg_l), 12'(seg_inv));
      end
    end
    upd_m = (next_score != snap_m);
    if (upd_m) blink_m = 2 * BF - 1;
    else if (blink_m != 0) blink_m--;
    snap_m = next_score;
  endtask

  task automatic frames(input logic [11:0] next_score, input logic en, input int n);
    for (int k = 0; k < n; k++) frame(next_score, en);
  endtask

  task automatic do_reset(input logic [11:0] sc, input int pre);
    for (int i = 0; i < pre; i++) step();
    resetn      = 1'b0;
    score_value = sc;
    sb.delete();
    step();
    check("rst_an_h", 12'(an_h), 12'h000);
    check("rst_seg_h", 12'(seg_h), 12'h000);
    check("rst_upd_h", 12'(upd_h), 12'h000);
    check("rst_an_l", 12'(an_l), 12'h007);
    check("rst_seg_l", 12'(seg_l), 12'h07F);
    check("rst_upd_l", 12'(upd_l), 12'h000);
    step();
    resetn  = 1'b1;
    snap_m  = 12'h000;
    blink_m = 0;
    upd_m   = 1'b0;
  endtask

  initial begin
    resetn      = 1'b0;
    enable      = 1'b1;
    score_value = 12'h123;
    do_reset(12'h123, 2);

    frames(12'h123, 1'b1, 5);
    frames(12'h007, 1'b1, 5);
    frames(12'h040, 1'b1, 5);
    frames(12'h1A5, 1'b1, 5);
    frames(12'h0A0, 1'b1, 5);
    frames(12'h010, 1'b1, 5);
    frames(12'h011, 1'b1, 5);
    frames(12'h005, 1'b1, 5);
    frames(12'h006, 1'b0, 2);
    frames(12'h006, 1'b1, 4);
    frames(12'h999, 1'b1, 5);
    frames(12'h000, 1'b1, 5);
    frames(12'h999, 1'b1, 2);

    do_reset(12'h000, 5);
    frames(12'h000, 1'b1, 3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/score_display_driver.md
Name: score_display_driver

Overview:
Reader side of the 12-bit BCD score bus {hundreds, tens, ones}. It latches the score once per scan frame so the display never tears, then drives a time-multiplexed 3-digit 7-segment display. It blanks leading zeros and shows a dash for any invalid BCD nibble. On every score change it flashes the display for a few frames. It sits between the score counter and the board's 7-segment pins.

Parameters:
REFRESH_DIV, 50000, clk cycles each digit slot is held (>=2)
BLINK_FRAMES, 2, blank/show pairs flashed after a score change; 0 disables flashing
ACTIVE_LOW, 1, 1 = seg and an outputs are active-low (inverted); 0 = active-high

Ports:
clk  input  1  system clock
resetn  input  1  reset, synchronous, active-low
enable  input  1  display on; when low, all digits are dark (scan keeps running)
score_value  input  12  BCD score: [11:8] hundreds, [7:4] tens, [3:0] ones
seg  output  7  segments {g,f,e,d,c,b,a}, polarity per ACTIVE_LOW
an  output  3  one-hot digit select: bit0 ones, bit1 tens, bit2 hundreds; polarity per ACTIVE_LOW
updated  output  1  one-cycle pulse when the latched score differs from the previous latch

Behaviour:
- Reset (resetn low at a clk edge): tick_cnt=0, slot=ONES, snap=0, blink_cnt=0, updated=0. All an and all seg inactive (all 1s if ACTIVE_LOW, all 0s otherwise). Reset wins over every other event, including mid-frame and mid-blink.
- Divider:
  - tick_cnt counts 0..REFRESH_DIV-1 and wraps.
  - tick is asserted for one cycle when tick_cnt == REFRESH_DIV-1.
- Slot FSM: ONES -> TENS -> HUNDS -> ONES. Advances only on tick.
- Frame boundary: tick while slot==HUNDS. On that edge:
  - snap <= score_value.
  - If score_value != snap: updated=1 for that cycle, and blink_cnt <= 2*BLINK_FRAMES-1 (skipped when BLINK_FRAMES=0).
  - Otherwise, if blink_cnt != 0, blink_cnt decrements. A reload has priority over the decrement.
- score_value is sampled only at frame boundaries. Changes between boundaries are ignored until the next boundary.
- Digit decode (active-high codes, hex):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble A-F = dash 40. Blank = 00.
- Leading-zero blanking:
  - Hundreds blank if snap[11:8]==0.
  - Tens blank if snap[11:8]==0 and snap[7:4]==0.
  - Ones always shown.
  - An invalid nibble is never blanked; it shows a dash and counts as nonzero for blanking decisions.
- Output stage:
  - an and seg are registered, one cycle behind the slot: the cycle after slot X is entered, an selects X and seg shows X's code.
  - If enable==0, or blink_cnt is odd, then an is all inactive and seg is blank.
  - If ACTIVE_LOW, an and seg are bitwise inverted after all of the above.
- Latency: a score change reaches the pins within 3*REFRESH_DIV+2 cycles.
- Widths:
  - tick_cnt is clog2(REFRESH_DIV) bits.
  - blink_cnt is clog2(2*BLINK_FRAMES)+1 bits.
  - No arithmetic on score digits; decode is a pure lookup.
- enable toggling: affects only the output stage. Divider, FSM, snap and blink keep running.
- Score wrap 999 -> 000: treated as a normal change (updated pulses, flash starts); shows "0" on the ones digit only.

Test Plan:
1. REFRESH_DIV=4, ACTIVE_LOW=0, hold score 0x123 through reset release -> after the first frame boundary, an cycles 001,010,100 every 4 clks; seg shows 4F, 5B, 06 respectively.
2. Score 0x007 -> ones shows 07; tens and hundreds slots show seg=00. Score 0x040 -> ones 3F, tens 66, hundreds 00.
3. Score 0x1A5 -> tens shows dash 40 and hundreds shows 06. Score 0x0A0 -> tens shows dash (not blanked) and ones shows 3F.
4. BLINK_FRAMES=2, change score 0x010 -> 0x011 mid-frame:
   - Mid-frame: no display change before the next boundary.
   - At the boundary: updated pulses exactly once.
   - Next four frames: dark, lit, dark, lit.
   - After that: steady display.
5. enable=0 for 2 frames while the score changes 0x005 -> 0x006 -> an all inactive. updated still pulses at the boundary. On enable=1, "6" appears with the blink state continuing unaffected.
6. ACTIVE_LOW=1, assert resetn=0 mid-blink on score 0x999 -> next cycle an=111, seg=7F, updated=0. After release, display "0" (ones only) with no flash.
